// File: rtl/data_mem_responder_pkg.sv
// Shared types and default sizes for the data-memory responder.
//   dmem_state_t     : responder FSM state encoding
//   DMEM_ADDR_WIDTH  : default word-address width
//   DMEM_DATA_WIDTH  : default data width (multiple of 8)
//   DMEM_DEPTH       : default number of implemented words
//   DMEM_WAIT_STATES : default wait states between acceptance and array access
package data_mem_responder_pkg;

   localparam int unsigned DMEM_ADDR_WIDTH  = 8;
   localparam int unsigned DMEM_DATA_WIDTH  = 16;
   localparam int unsigned DMEM_DEPTH       = 256;
   localparam int unsigned DMEM_WAIT_STATES = 2;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StAccess,
      StRespond
   } dmem_state_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the CPU data port and the data-memory responder.
//   master : CPU side (drives requests, consumes responses)
//   slave  : memory side (accepts requests, produces responses)
// Optional macro DMEM_WSTRB_EN adds req_wstrb, one bit per byte lane.
interface data_mem_responder_if
   import data_mem_responder_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DMEM_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = DMEM_DATA_WIDTH
) ();

   logic                    req_valid;
   logic                    req_ready;
   logic                    req_write;
   logic [ADDR_WIDTH-1:0]   req_addr;
   logic [DATA_WIDTH-1:0]   req_wdata;
`ifdef DMEM_WSTRB_EN
   logic [DATA_WIDTH/8-1:0] req_wstrb;
`endif
   logic                    rsp_valid;
   logic                    rsp_ready;
   logic [DATA_WIDTH-1:0]   rsp_rdata;
   logic                    rsp_err;

   modport master (
`ifdef DMEM_WSTRB_EN
      output req_wstrb,
`endif
      output req_valid, req_write, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
`ifdef DMEM_WSTRB_EN
      input  req_wstrb,
`endif
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/data_mem_responder_dmem_array.sv
// Single-port synchronous RAM with per-byte write enables and no reset.
//   clk   : clock
//   en    : access enable; a read updates rdata only when en && !we
//   we    : write enable
//   be    : byte-lane enables for writes
//   addr  : word address (caller guarantees addr < DEPTH when en is high)
//   wdata : write data
//   rdata : registered read data
module dmem_array
   import data_mem_responder_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DMEM_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = DMEM_DATA_WIDTH,
   parameter int unsigned DEPTH      = DMEM_DEPTH
) (
   input  logic                    clk,
   input  logic                    en,
   input  logic                    we,
   input  logic [DATA_WIDTH/8-1:0] be,
   input  logic [ADDR_WIDTH-1:0]   addr,
   input  logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH-1:0]   rdata
);

   localparam int unsigned Lanes = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < Lanes; i++) begin
               if (be[i]) mem_q[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
         end else begin
            rdata_q <= mem_q[addr];
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU data port: one outstanding load/store,
// WAIT_STATES wait cycles, then one array access, then a response held until
// the CPU takes it.
//   clk     : clock, all state changes on the rising edge
//   reset_n : synchronous active-low reset
//   bus     : request/response channel (slave modport)
// Optional macro DMEM_WSTRB_EN enables byte-lane write strobes.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = DMEM_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH  = DMEM_DATA_WIDTH,
   parameter int unsigned DEPTH       = DMEM_DEPTH,
   parameter int unsigned WAIT_STATES = DMEM_WAIT_STATES
) (
   input logic                 clk,
   input logic                 reset_n,
   data_mem_responder_if.slave bus
);

   localparam int unsigned Lanes = DATA_WIDTH / 8;
   localparam int unsigned CntW  = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
   localparam logic [CntW-1:0]     CntLoad  = (WAIT_STATES > 0) ? CntW'(WAIT_STATES - 1) : '0;
   localparam logic [ADDR_WIDTH:0] DepthCmp = DEPTH[ADDR_WIDTH:0];

   dmem_state_t           state_q, state_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_err_q, rsp_err_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

   logic                  write_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [Lanes-1:0]      be;

   logic                  req_ready;
   logic                  latch_en;
   logic                  ram_en;
   logic                  ram_we;
   logic [DATA_WIDTH-1:0] ram_rdata;
   logic                  addr_err;

   assign addr_err = ({1'b0, addr_q} >= DepthCmp);

   // Request latches carry no reset; they are only consumed after a fresh accept.
`ifdef DMEM_WSTRB_EN
   logic [Lanes-1:0] be_q;
   always_ff @(posedge clk) begin
      if (latch_en) be_q <= bus.req_wstrb;
   end
   assign be = be_q;
`else
   assign be = '1;
`endif

   always_ff @(posedge clk) begin
      if (latch_en) begin
         write_q <= bus.req_write;
         addr_q  <= bus.req_addr;
         wdata_q <= bus.req_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rsp_valid_d = rsp_valid_q;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;
      req_ready   = 1'b0;
      latch_en    = 1'b0;
      ram_en      = 1'b0;
      unique case (state_q)
         StIdle: begin
            req_ready = 1'b1;
            if (bus.req_valid) begin
               latch_en = 1'b1;
               cnt_d    = CntLoad;
               state_d  = (WAIT_STATES > 0) ? StWait : StAccess;
            end
         end
         StWait: begin
            if (cnt_q == '0) state_d = StAccess;
            else             cnt_d   = cnt_q - 1'b1;
         end
         StAccess: begin
            ram_en  = !addr_err;
            state_d = StRespond;
         end
         StRespond: begin
            // First RESPOND cycle captures the RAM output into the response
            // registers; afterwards they hold until the handshake.
            if (!rsp_valid_q) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = addr_err;
               rsp_rdata_d = (addr_err || write_q) ? '0 : ram_rdata;
            end else if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               rsp_err_d   = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // A store reaching ACCESS commits only if reset is not asserted at that edge.
   assign ram_we = ram_en && write_q && reset_n;

   dmem_array #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_dmem_array (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .be    (be),
      .addr  (addr_q),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

   assign bus.req_ready = req_ready;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder. Instance a: WAIT_STATES=2, DEPTH=200.
// Instance b: WAIT_STATES=0, DEPTH=256. Byte-strobe cases run when DMEM_WSTRB_EN is defined.
module tb_data_mem_responder;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;

   logic [1:0]  req_valid, req_write, rsp_ready;
   logic [7:0]  req_addr  [2];
   logic [15:0] req_wdata [2];
   logic [1:0]  req_ready, rsp_valid, rsp_err;
   logic [15:0] rsp_rdata [2];

   data_mem_responder_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus_a ();
   data_mem_responder_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus_b ();

   data_mem_responder #(
      .ADDR_WIDTH  (8),
      .DATA_WIDTH  (16),
      .DEPTH       (200),
      .WAIT_STATES (2)
   ) u_dut_a (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_a)
   );

   data_mem_responder #(
      .ADDR_WIDTH  (8),
      .DATA_WIDTH  (16),
      .DEPTH       (256),
      .WAIT_STATES (0)
   ) u_dut_b (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_b)
   );

   assign bus_a.req_valid = req_valid[0];
   assign bus_a.req_write = req_write[0];
   assign bus_a.req_addr  = req_addr[0];
   assign bus_a.req_wdata = req_wdata[0];
   assign bus_a.rsp_ready = rsp_ready[0];
   assign bus_b.req_valid = req_valid[1];
   assign bus_b.req_write = req_write[1];
   assign bus_b.req_addr  = req_addr[1];
   assign bus_b.req_wdata = req_wdata[1];
   assign bus_b.rsp_ready = rsp_ready[1];

   assign req_ready = {bus_b.req_ready, bus_a.req_ready};
   assign rsp_valid = {bus_b.rsp_valid, bus_a.rsp_valid};
   assign rsp_err   = {bus_b.rsp_err, bus_a.rsp_err};
   assign rsp_rdata[0] = bus_a.rsp_rdata;
   assign rsp_rdata[1] = bus_b.rsp_rdata;

`ifdef DMEM_WSTRB_EN
   logic [1:0] req_wstrb [2];
   assign bus_a.req_wstrb = req_wstrb[0];
   assign bus_b.req_wstrb = req_wstrb[1];
`endif

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // One complete transaction on instance d, checking latency, busy req_ready,
   // response contents (also while held under backpressure) and the handshake.
   task automatic do_txn(input int d, input string name, input logic wr, input logic [7:0] addr,
                         input logic [15:0] wdata, input int exp_lat, input int hold,
                         input logic [15:0] exp_rdata, input logic exp_err);
      int   n;
      logic ready_seen;
      @(negedge clk);
      check_eq({name, ".ready_idle"}, 32'(req_ready[d]), 32'd1);
      req_valid[d] = 1'b1;
      req_write[d] = wr;
      req_addr[d]  = addr;
      req_wdata[d] = wdata;
      @(posedge clk);
      @(negedge clk);
      req_valid[d] = 1'b0;
      n = 0;
      ready_seen = 1'b0;
      while (!rsp_valid[d] && n < 20) begin
         if (req_ready[d]) ready_seen = 1'b1;
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      if (!rsp_valid[d]) begin
         check_eq({name, ".rsp_timeout"}, 32'd0, 32'd1);
         return;
      end
      check_eq({name, ".latency"}, 32'(n), 32'(exp_lat));
      check_eq({name, ".ready_busy"}, 32'(ready_seen), 32'd0);
      check_eq({name, ".rdata"}, 32'(rsp_rdata[d]), 32'(exp_rdata));
      check_eq({name, ".err"}, 32'(rsp_err[d]), 32'(exp_err));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         @(negedge clk);
         check_eq({name, ".hold_valid"}, 32'(rsp_valid[d]), 32'd1);
         check_eq({name, ".hold_rdata"}, 32'(rsp_rdata[d]), 32'(exp_rdata));
         check_eq({name, ".hold_ready"}, 32'(req_ready[d]), 32'd0);
      end
      check_eq({name, ".ready_rsp"}, 32'(req_ready[d]), 32'd0);
      rsp_ready[d] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready[d] = 1'b0;
      check_eq({name, ".valid_clr"}, 32'(rsp_valid[d]), 32'd0);
      check_eq({name, ".err_clr"}, 32'(rsp_err[d]), 32'd0);
      check_eq({name, ".ready_after"}, 32'(req_ready[d]), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic seen;
      reset_n   = 1'b0;
      req_valid = '0;
      req_write = '0;
      rsp_ready = '0;
      for (int i = 0; i < 2; i++) begin
         req_addr[i]  = '0;
         req_wdata[i] = '0;
`ifdef DMEM_WSTRB_EN
         req_wstrb[i] = 2'b11;
`endif
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      for (int d = 0; d < 2; d++) begin
         check_eq("reset.req_ready", 32'(req_ready[d]), 32'd1);
         check_eq("reset.rsp_valid", 32'(rsp_valid[d]), 32'd0);
         check_eq("reset.rsp_err", 32'(rsp_err[d]), 32'd0);
         check_eq("reset.rsp_rdata", 32'(rsp_rdata[d]), 32'd0);
      end

      // Instance a: two wait states, DEPTH=200.
      do_txn(0, "a_st05", 1'b1, 8'h05, 16'hBEEF, 4, 0, 16'h0000, 1'b0);
      do_txn(0, "a_ld05", 1'b0, 8'h05, 16'h0000, 4, 0, 16'hBEEF, 1'b0);
      do_txn(0, "a_st10", 1'b1, 8'h10, 16'hA5A5, 4, 0, 16'h0000, 1'b0);
      do_txn(0, "a_ld10_bp", 1'b0, 8'h10, 16'h0000, 4, 5, 16'hA5A5, 1'b0);
      do_txn(0, "a_st199", 1'b1, 8'd199, 16'h2222, 4, 0, 16'h0000, 1'b0);
      do_txn(0, "a_st200", 1'b1, 8'd200, 16'h7777, 4, 1, 16'h0000, 1'b1);
      do_txn(0, "a_ld199", 1'b0, 8'd199, 16'h0000, 4, 0, 16'h2222, 1'b0);
      do_txn(0, "a_ld200", 1'b0, 8'd200, 16'h0000, 4, 0, 16'h0000, 1'b1);

      // Reset during WAIT abandons a store.
      do_txn(0, "a_st03", 1'b1, 8'h03, 16'h1111, 4, 0, 16'h0000, 1'b0);
      @(negedge clk);
      req_valid[0] = 1'b1;
      req_write[0] = 1'b1;
      req_addr[0]  = 8'h03;
      req_wdata[0] = 16'h5555;
      @(posedge clk);
      @(negedge clk);
      req_valid[0] = 1'b0;
      reset_n      = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      check_eq("rst_wait.req_ready", 32'(req_ready[0]), 32'd1);
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (rsp_valid[0]) seen = 1'b1;
      end
      check_eq("rst_wait.no_rsp", 32'(seen), 32'd0);
      do_txn(0, "a_ld03", 1'b0, 8'h03, 16'h0000, 4, 0, 16'h1111, 1'b0);

      // Instance b: zero wait states, DEPTH=256.
      do_txn(1, "b_st00", 1'b1, 8'h00, 16'h1234, 2, 0, 16'h0000, 1'b0);
      do_txn(1, "b_ld00", 1'b0, 8'h00, 16'h0000, 2, 2, 16'h1234, 1'b0);
      do_txn(1, "b_st255", 1'b1, 8'hFF, 16'h0F0F, 2, 0, 16'h0000, 1'b0);
      do_txn(1, "b_ld255", 1'b0, 8'hFF, 16'h0000, 2, 0, 16'h0F0F, 1'b0);

`ifdef DMEM_WSTRB_EN
      do_txn(0, "w_st07", 1'b1, 8'h07, 16'hABCD, 4, 0, 16'h0000, 1'b0);
      req_wstrb[0] = 2'b01;
      do_txn(0, "w_st07_lo", 1'b1, 8'h07, 16'h1234, 4, 0, 16'h0000, 1'b0);
      req_wstrb[0] = 2'b11;
      do_txn(0, "w_ld07_lo", 1'b0, 8'h07, 16'h0000, 4, 0, 16'hAB34, 1'b0);
      do_txn(0, "w_st07_b", 1'b1, 8'h07, 16'hABCD, 4, 0, 16'h0000, 1'b0);
      req_wstrb[0] = 2'b00;
      do_txn(0, "w_st07_none", 1'b1, 8'h07, 16'h1234, 4, 0, 16'h0000, 1'b0);
      req_wstrb[0] = 2'b11;
      do_txn(0, "w_ld07_none", 1'b0, 8'h07, 16'h0000, 4, 0, 16'hABCD, 1'b0);
      req_wstrb[0] = 2'b10;
      do_txn(0, "w_st07_hi", 1'b1, 8'h07, 16'h1234, 4, 0, 16'h0000, 1'b0);
      req_wstrb[0] = 2'b11;
      do_txn(0, "w_ld07_hi", 1'b0, 8'h07, 16'h0000, 4, 0, 16'h12CD, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
